// File: rtl/rvhazard_pkg.sv
// Shared types and defaults for the RV32I pipeline hazard controller.
package rvhazard_pkg;

  localparam int unsigned MEM_TIMEOUT_DEFAULT = 64;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    MEMWAIT = 1'b1
  } hz_state_e;

  // M has the younger result, so it takes priority over W; x0 never forwards.
  function automatic fwd_sel_e fwd_select(
    input logic [4:0] rs,
    input logic       we_m,
    input logic [4:0] rd_m,
    input logic       we_w,
    input logic [4:0] rd_w
  );
    if (we_m && rd_m != 5'd0 && rd_m == rs) return FWD_MEM;
    if (we_w && rd_w != 5'd0 && rd_w == rs) return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/rvhazard_perfcnt.sv
// Saturating event counter with asynchronous active-low reset.
module rvhazard_perfcnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/rvhazard_unit.sv
// Stall/flush/forward controller with a data-memory wait FSM and timeout.
module rvhazard_unit
  import rvhazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       rdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             RegWriteM,
  input  logic [4:0]       rdM,
  input  logic             RegWriteW,
  input  logic [4:0]       rdW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [CNT_W-1:0] LoadUseCnt
);

  localparam int unsigned WC_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e         state, state_nxt;
  logic [WC_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic              timeout_set;
  logic              lw_stall, load_use, mem_wait;
  logic              stall_fd, flush_d, flush_e;
  fwd_sel_e          fwd_a, fwd_b;

  assign fwd_a = fwd_select(Rs1E, RegWriteM, rdM, RegWriteW, rdW);
  assign fwd_b = fwd_select(Rs2E, RegWriteM, rdM, RegWriteW, rdW);

  assign lw_stall = ResultSrcE[0] && rdE != 5'd0 && (Rs1D == rdE || Rs2D == rdE);

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
    mem_wait     = 1'b0;
    load_use     = 1'b0;
    stall_fd     = 1'b0;
    flush_d      = 1'b0;
    flush_e      = 1'b0;
    if (state == RUN) begin
      if (MemReqM && !MemAckM) begin
        mem_wait = 1'b1;
        if (MEM_TIMEOUT <= 1) begin
          timeout_set = 1'b1;
        end else begin
          state_nxt    = MEMWAIT;
          wait_cnt_nxt = WC_W'(1);
        end
      end else if (PCSrcE) begin
        flush_d = 1'b1;
        flush_e = 1'b1;
      end else if (lw_stall) begin
        load_use = 1'b1;
        stall_fd = 1'b1;
        flush_e  = 1'b1;
      end
    end else begin
      // A dropped request counts as completion; the ack cycle itself still stalls.
      mem_wait = 1'b1;
      if (MemAckM || !MemReqM) begin
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end else if (32'(wait_cnt) + 32'd1 == MEM_TIMEOUT) begin
        timeout_set  = 1'b1;
        state_nxt    = RUN;
        wait_cnt_nxt = '0;
      end else begin
        wait_cnt_nxt = wait_cnt + WC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= RUN;
      wait_cnt   <= '0;
      MemTimeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_set) MemTimeout <= 1'b1;
    end
  end

  // Reset gating keeps every combinational control quiet while reset is low.
  assign StallF    = reset & (mem_wait | stall_fd);
  assign StallD    = reset & (mem_wait | stall_fd);
  assign StallE    = reset & mem_wait;
  assign StallM    = reset & mem_wait;
  assign FlushD    = reset & flush_d;
  assign FlushE    = reset & flush_e;
  assign FlushW    = reset & mem_wait;
  assign ForwardAE = reset ? fwd_a : FWD_RF;
  assign ForwardBE = reset ? fwd_b : FWD_RF;

  rvhazard_perfcnt #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (StallD),
    .count (StallCnt)
  );

  rvhazard_perfcnt #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (FlushD | FlushE),
    .count (FlushCnt)
  );

  rvhazard_perfcnt #(.W(CNT_W)) u_load_use_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (reset & load_use),
    .count (LoadUseCnt)
  );

endmodule

// File: tb/tb_rvhazard_unit.sv
// Directed scoreboard bench for rvhazard_unit (MEM_TIMEOUT=4, 3-bit counters).
module tb_rvhazard_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0, rdE = '0, rdM = '0, rdW = '0;
  logic [1:0] ResultSrcE = '0;
  logic       RegWriteM = 1'b0, RegWriteW = 1'b0, PCSrcE = 1'b0, MemReqM = 1'b0, MemAckM = 1'b0;
  logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
  logic [1:0] ForwardAE, ForwardBE;
  logic [2:0] StallCnt, FlushCnt, LoadUseCnt;

  rvhazard_unit #(.MEM_TIMEOUT(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .rdE(rdE),
    .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .rdM(rdM),
    .RegWriteW(RegWriteW), .rdW(rdW), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemAckM(MemAckM),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeout(MemTimeout),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .LoadUseCnt(LoadUseCnt)
  );

  always #5 clk = ~clk;

  // ctrl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] C_NONE = 7'b0000_000;
  localparam logic [6:0] C_LU   = 7'b1100_010;
  localparam logic [6:0] C_BR   = 7'b0000_110;
  localparam logic [6:0] C_MW   = 7'b1111_001;

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    logic [3:0] fwd;
    logic       tmo;
    logic [2:0] sc, fc, lc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push(input string n, input logic [6:0] c, input logic [3:0] f,
                      input logic t, input logic [2:0] s, input logic [2:0] fl,
                      input logic [2:0] l);
    exp_t x;
    x.name = n; x.ctrl = c; x.fwd = f; x.tmo = t; x.sc = s; x.fc = fl; x.lc = l;
    sb.push_back(x);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; rdE = '0; rdM = '0; rdW = '0;
    ResultSrcE = '0; RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
    MemReqM = 1'b0; MemAckM = 1'b0;
  endtask

  task automatic set_lw();
    ResultSrcE = 2'b01; rdE = 5'd7; Rs1D = 5'd7;
  endtask

  // Monitor: one expected entry is presented per cycle, checked mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      logic [6:0] ac;
      logic [3:0] af;
      logic [9:0] as, es;
      e  = sb.pop_front();
      ac = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
      af = {ForwardAE, ForwardBE};
      as = {MemTimeout, StallCnt, FlushCnt, LoadUseCnt};
      es = {e.tmo, e.sc, e.fc, e.lc};
      n_checks++;
      if (ac === e.ctrl) n_pass++;
      else $display("FAIL %s ctrl got %b want %b", e.name, ac, e.ctrl);
      n_checks++;
      if (af === e.fwd) n_pass++;
      else $display("FAIL %s fwd got %b want %b", e.name, af, e.fwd);
      n_checks++;
      if (as === es) n_pass++;
      else $display("FAIL %s tmo/stall/flush/lu got %b want %b", e.name, as, es);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    nxt();
    RegWriteM = 1'b1; rdM = 5'd5; Rs1E = 5'd5; MemReqM = 1'b1; set_lw();
    push("in_reset", C_NONE, 4'b0000, 0, 0, 0, 0);

    nxt(); reset = 1'b1; clr();
    RegWriteM = 1'b1; rdM = 5'd5; RegWriteW = 1'b1; rdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
    push("fwd_m_wins", C_NONE, 4'b1010, 0, 0, 0, 0);
    nxt(); rdM = 5'd0;
    push("fwd_w_rdm0", C_NONE, 4'b0101, 0, 0, 0, 0);
    nxt(); rdM = 5'd3; Rs1E = 5'd3;
    push("fwd_mixed", C_NONE, 4'b1001, 0, 0, 0, 0);
    nxt(); rdM = 5'd0; rdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    push("fwd_x0", C_NONE, 4'b0000, 0, 0, 0, 0);
    nxt(); RegWriteM = 1'b0; RegWriteW = 1'b0; rdM = 5'd5; rdW = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
    push("fwd_no_we", C_NONE, 4'b0000, 0, 0, 0, 0);

    nxt(); clr(); ResultSrcE = 2'b01; rdE = 5'd7; Rs2D = 5'd7;
    push("load_use", C_LU, 4'b0000, 0, 0, 0, 0);
    nxt(); clr();
    push("after_lu", C_NONE, 4'b0000, 0, 1, 1, 1);
    nxt(); ResultSrcE = 2'b01; rdE = 5'd0;
    push("lu_rd0", C_NONE, 4'b0000, 0, 1, 1, 1);
    nxt(); ResultSrcE = 2'b10; rdE = 5'd7; Rs1D = 5'd7;
    push("not_load", C_NONE, 4'b0000, 0, 1, 1, 1);
    nxt(); clr(); set_lw(); PCSrcE = 1'b1;
    push("branch_vs_lu", C_BR, 4'b0000, 0, 1, 1, 1);
    nxt(); clr();
    push("after_br", C_NONE, 4'b0000, 0, 1, 2, 1);

    nxt(); set_lw(); MemReqM = 1'b1;
    push("mw1_lu_masked", C_MW, 4'b0000, 0, 1, 2, 1);
    nxt(); clr(); MemReqM = 1'b1; PCSrcE = 1'b1;
    push("mw2_br_masked", C_MW, 4'b0000, 0, 2, 2, 1);
    nxt(); PCSrcE = 1'b0;
    push("mw3", C_MW, 4'b0000, 0, 3, 2, 1);
    nxt(); MemAckM = 1'b1;
    push("mw_ack", C_MW, 4'b0000, 0, 4, 2, 1);
    nxt(); clr();
    push("mw_release", C_NONE, 4'b0000, 0, 5, 2, 1);
    nxt(); MemReqM = 1'b1; MemAckM = 1'b1;
    push("same_cycle_ack", C_NONE, 4'b0000, 0, 5, 2, 1);
    nxt(); clr();
    push("idle1", C_NONE, 4'b0000, 0, 5, 2, 1);

    nxt(); MemReqM = 1'b1;
    push("drop1", C_MW, 4'b0000, 0, 5, 2, 1);
    nxt(); MemReqM = 1'b0;
    push("drop_as_ack", C_MW, 4'b0000, 0, 6, 2, 1);
    nxt();
    push("drop_release", C_NONE, 4'b0000, 0, 7, 2, 1);

    nxt(); MemReqM = 1'b1;
    push("to_w1", C_MW, 4'b0000, 0, 7, 2, 1);
    nxt(); push("to_w2", C_MW, 4'b0000, 0, 7, 2, 1);
    nxt(); push("to_w3", C_MW, 4'b0000, 0, 7, 2, 1);
    nxt(); push("to_w4", C_MW, 4'b0000, 0, 7, 2, 1);
    nxt(); MemReqM = 1'b0;
    push("to_fired", C_NONE, 4'b0000, 1, 7, 2, 1);
    nxt(); push("to_sticky", C_NONE, 4'b0000, 1, 7, 2, 1);

    nxt(); MemReqM = 1'b1;
    push("rst_w1", C_MW, 4'b0000, 1, 7, 2, 1);
    nxt(); push("rst_w2", C_MW, 4'b0000, 1, 7, 2, 1);
    nxt(); #2 reset = 1'b0;
    push("rst_async", C_NONE, 4'b0000, 0, 0, 0, 0);
    nxt(); set_lw(); RegWriteW = 1'b1; rdW = 5'd4; Rs2E = 5'd4;
    push("rst_held", C_NONE, 4'b0000, 0, 0, 0, 0);
    nxt(); clr(); reset = 1'b1; MemReqM = 1'b1; MemAckM = 1'b1;
    push("rst_run", C_NONE, 4'b0000, 0, 0, 0, 0);
    nxt(); clr();
    push("rst_idle", C_NONE, 4'b0000, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain queue got %0d want 0", sb.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
